// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged reset release for a single-clock system. After the system reset
//   is released and the clock generator reports lock, all resets are held
//   for HOLD_CYCLES. They are then released in order: interconnect first,
//   then peripherals, then the processor, with STAGE_GAP cycles between steps.
//   Lock loss or a software request re-runs the sequence. Each such warm
//   reset is counted in rst_count, which saturates at 255.
//
// Ports
//   clk_100MHz    in   system clock, rising edge
//   sysreset_n    in   asynchronous active-low system reset
//   ext_lock      in   clock-generator lock, asynchronous to clk_100MHz
//   sw_reset_req  in   single-cycle software reset request (honoured in RUN)
//   bus_rst_n     out  interconnect reset, active-low, released first
//   periph_rst_n  out  peripheral reset, active-low, released second
//   cpu_rst_n     out  processor reset, active-low, released last
//   rst_done      out  high only in RUN
//   rst_count     out  saturating warm-reset event count
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RESET      | waiting for the synchronized release of sysreset_n
// WAIT_LOCK  | all resets asserted, waiting for lock_s
// HOLD       | all resets asserted for HOLD_CYCLES
// REL_BUS    | bus released, STAGE_GAP cycles before peripherals
// REL_PERIPH | bus and peripherals released, STAGE_GAP cycles before cpu
// RUN        | everything released, rst_done high
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic       clk_100MHz,
    input  logic       sysreset_n,
    input  logic       ext_lock,
    input  logic       sw_reset_req,
    output logic       bus_rst_n,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic       rst_done,
    output logic [7:0] rst_count
);

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        HOLD,
        REL_BUS,
        REL_PERIPH,
        RUN
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(STAGE_GAP - 1);

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   rst_rel;
    logic                   lock_s;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] count_q, count_d;
    logic       count_evt;
    logic       bus_q, bus_d;
    logic       periph_q, periph_d;
    logic       cpu_q, cpu_d;

    // Both synchronizers clear asynchronously with sysreset_n. A '1' walks
    // through rst_sync_q, so the internal release needs SYNC_STAGES edges.
    always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
        if (!sysreset_n) begin
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], ext_lock};
        end
    end

    assign rst_rel = rst_sync_q[SYNC_STAGES-1];
    assign lock_s  = lock_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_100MHz or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q  <= RESET;
            cnt_q    <= '0;
            count_q  <= '0;
            bus_q    <= 1'b0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            bus_q    <= bus_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_evt = 1'b0;
        case (state_q)
            RESET: begin
                if (rst_rel) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD, REL_BUS, REL_PERIPH: begin
                if (!lock_s) begin
                    state_d   = WAIT_LOCK;
                    count_evt = 1'b1;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    cnt_d = GAP_LOAD;
                    case (state_q)
                        HOLD:    state_d = REL_BUS;
                        REL_BUS: state_d = REL_PERIPH;
                        default: state_d = RUN;
                    endcase
                end
            end
            RUN: begin
                // lock loss outranks a simultaneous software request
                if (!lock_s) begin
                    state_d   = WAIT_LOCK;
                    count_evt = 1'b1;
                end else if (sw_reset_req) begin
                    state_d   = HOLD;
                    cnt_d     = HOLD_LOAD;
                    count_evt = 1'b1;
                end
            end
            default: state_d = RESET;
        endcase

        count_d = (count_evt && count_q != 8'hFF) ? count_q + 8'd1 : count_q;

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state does.
        bus_d    = (state_d == REL_BUS) || (state_d == REL_PERIPH) || (state_d == RUN);
        periph_d = (state_d == REL_PERIPH) || (state_d == RUN);
        cpu_d    = (state_d == RUN);
    end

    assign bus_rst_n    = bus_q;
    assign periph_rst_n = periph_q;
    assign cpu_rst_n    = cpu_q;
    assign rst_done     = cpu_q;
    assign rst_count    = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int SS    = 2;
    localparam int HC    = 16;
    localparam int SG    = 4;
    localparam int T_BUS = HC;
    localparam int T_PER = HC + SG;
    localparam int T_RUN = HC + 2 * SG;

    logic       clk = 1'b0;
    logic       sysreset_n = 1'b1;
    logic       ext_lock = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       bus_rst_n, periph_rst_n, cpu_rst_n, rst_done;
    logic [7:0] rst_count;

    int vectors = 0;
    int miscompares = 0;

    reset_sequencer #(.SYNC_STAGES(SS), .HOLD_CYCLES(HC), .STAGE_GAP(SG)) dut (
        .clk_100MHz  (clk),
        .sysreset_n  (sysreset_n),
        .ext_lock    (ext_lock),
        .sw_reset_req(sw_reset_req),
        .bus_rst_n   (bus_rst_n),
        .periph_rst_n(periph_rst_n),
        .cpu_rst_n   (cpu_rst_n),
        .rst_done    (rst_done),
        .rst_count   (rst_count)
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {bus_rst_n, periph_rst_n, cpu_rst_n, rst_done, rst_count};

    // Reference model: phase 0 = in reset, 1 = waiting for lock,
    // 2 = sequencing, with m_t counting edges since the sequence started.
    // Each output is a threshold on m_t.
    int          m_phase, m_t, m_rel, m_count;
    logic [SS-1:0] m_hist;
    logic [11:0] exp_v;

    always @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            m_phase <= 0; m_t <= 0; m_rel <= 0; m_count <= 0; m_hist <= '0;
        end else begin
            m_rel  <= (m_rel < SS) ? m_rel + 1 : m_rel;
            m_hist <= {m_hist[SS-2:0], ext_lock};
            if (m_phase == 0) begin
                if (m_rel >= SS) m_phase <= 1;
            end else if (m_phase == 1) begin
                if (m_hist[SS-1]) begin m_phase <= 2; m_t <= 0; end
            end else begin
                if (!m_hist[SS-1]) begin
                    m_phase <= 1;
                    m_count <= (m_count < 255) ? m_count + 1 : 255;
                end else if (sw_reset_req && m_t >= T_RUN) begin
                    m_t     <= 0;
                    m_count <= (m_count < 255) ? m_count + 1 : 255;
                end else if (m_t < T_RUN) begin
                    m_t <= m_t + 1;
                end
            end
        end
    end

    always_comb begin
        exp_v = {m_phase == 2 && m_t >= T_BUS, m_phase == 2 && m_t >= T_PER,
                 m_phase == 2 && m_t >= T_RUN, m_phase == 2 && m_t >= T_RUN, 8'(m_count)};
    end

    task automatic test_reset();
        #2 sysreset_n = 1'b0;
        ext_lock = 1'b1;
        #1 vectors++;
        if (obs !== 12'h000) begin
            miscompares++; $display("FAIL reset_async got=%h want=000", obs);
        end
        repeat (3) begin
            @(negedge clk); vectors++;
            if (obs !== exp_v || obs !== 12'h000) begin
                miscompares++; $display("FAIL reset_hold got=%h want=%h", obs, exp_v);
            end
        end
    endtask

    task automatic test_basic();
        int bus_e = -1, per_e = -1, cpu_e = -1;
        sysreset_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL basic cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (bus_rst_n === 1'b1 && bus_e < 0) bus_e = i;
            if (periph_rst_n === 1'b1 && per_e < 0) per_e = i;
            if (cpu_rst_n === 1'b1 && cpu_e < 0) cpu_e = i;
        end
        vectors++;
        if (bus_e < T_BUS + 1 || bus_e > T_BUS + 5 || per_e - bus_e != SG || cpu_e - bus_e != 2 * SG) begin
            miscompares++;
            $display("FAIL basic_timing got bus=%0d per=%0d cpu=%0d want bus in %0d..%0d per=bus+%0d cpu=bus+%0d",
                     bus_e, per_e, cpu_e, T_BUS + 1, T_BUS + 5, SG, 2 * SG);
        end
    endtask

    task automatic test_sw_reset();
        int bus_e = -1, cpu_e = -1;
        sw_reset_req = 1'b1;
        @(negedge clk); sw_reset_req = 1'b0; vectors++;
        if (obs !== exp_v || obs !== {4'b0000, 8'd1}) begin
            miscompares++; $display("FAIL sw_reset_entry got=%h want=%h", obs, {4'b0000, 8'd1});
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk); vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL sw_reset cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (bus_rst_n === 1'b1 && bus_e < 0) bus_e = i;
            if (cpu_rst_n === 1'b1 && cpu_e < 0) cpu_e = i;
        end
        vectors++;
        if (bus_e != T_BUS || cpu_e != T_RUN) begin
            miscompares++;
            $display("FAIL sw_reset_timing got bus=%0d cpu=%0d want bus=%0d cpu=%0d", bus_e, cpu_e, T_BUS, T_RUN);
        end
    endtask

    task automatic test_lock_drop();
        int budget = 0;
        sw_reset_req = 1'b1;
        @(negedge clk); sw_reset_req = 1'b0;
        while (!(bus_rst_n === 1'b1 && periph_rst_n === 1'b0) && budget < 40) begin
            @(negedge clk); budget++; vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL lock_drop_pre got=%h want=%h", obs, exp_v);
            end
        end
        vectors++;
        if (budget >= 40) begin
            miscompares++; $display("FAIL lock_drop_reach_rel_bus got=timeout want=REL_BUS");
        end
        ext_lock = 1'b0;
        repeat (4) begin
            @(negedge clk); vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL lock_drop got=%h want=%h", obs, exp_v);
            end
        end
        vectors++;
        if (obs !== {4'b0000, 8'd3}) begin
            miscompares++; $display("FAIL lock_drop_count got=%h want=%h", obs, {4'b0000, 8'd3});
        end
        ext_lock = 1'b1;
        repeat (6) @(negedge clk);
        sw_reset_req = 1'b1;
        @(negedge clk); sw_reset_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL hold_sw_ignored cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
        end
        vectors++;
        if (obs !== {4'b1111, 8'd3}) begin
            miscompares++; $display("FAIL hold_sw_count got=%h want=%h", obs, {4'b1111, 8'd3});
        end
    endtask

    task automatic test_async_abort();
        int budget = 0;
        sw_reset_req = 1'b1;
        @(negedge clk); sw_reset_req = 1'b0;
        while (!(periph_rst_n === 1'b1 && cpu_rst_n === 1'b0) && budget < 40) begin
            @(negedge clk); budget++; vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL abort_pre got=%h want=%h", obs, exp_v);
            end
        end
        vectors++;
        if (budget >= 40) begin
            miscompares++; $display("FAIL abort_reach_rel_periph got=timeout want=REL_PERIPH");
        end
        #2 sysreset_n = 1'b0;
        #1 vectors++;
        if (obs !== 12'h000 || obs !== exp_v) begin
            miscompares++; $display("FAIL abort_async got=%h want=000", obs);
        end
    endtask

    task automatic test_late_lock();
        @(negedge clk);
        ext_lock = 1'b0;
        sysreset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); vectors++;
            if (obs !== exp_v || obs !== 12'h000) begin
                miscompares++; $display("FAIL late_lock_wait cyc=%0d got=%h want=000", i, obs);
            end
        end
        ext_lock = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL late_lock cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
        end
        vectors++;
        if (obs !== {4'b1111, 8'd0}) begin
            miscompares++; $display("FAIL late_lock_run got=%h want=%h", obs, {4'b1111, 8'd0});
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 301; n++) begin
            int budget = 0;
            while (rst_done !== 1'b1 && budget < 40) begin
                @(negedge clk); budget++; vectors++;
                if (obs !== exp_v) begin
                    miscompares++; $display("FAIL saturation n=%0d got=%h want=%h", n, obs, exp_v);
                end
            end
            if (budget >= 40) begin
                vectors++; miscompares++;
                $display("FAIL saturation_run n=%0d got=timeout want=rst_done", n);
                break;
            end
            sw_reset_req = 1'b1;
            @(negedge clk); sw_reset_req = 1'b0; vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL saturation_pulse n=%0d got=%h want=%h", n, obs, exp_v);
            end
        end
        vectors++;
        if (rst_count !== 8'd255) begin
            miscompares++; $display("FAIL saturation_count got=%0d want=255", rst_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            sysreset_n   = 1'b1;
            sw_reset_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) ext_lock = ~ext_lock;
            if ($urandom_range(0, 299) == 0) begin
                #($urandom_range(1, 3)) sysreset_n = 1'b0;
                #1 vectors++;
                if (obs !== 12'h000 || obs !== exp_v) begin
                    miscompares++; $display("FAIL random_async cyc=%0d got=%h want=000", i, obs);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sw_reset();
        test_lock_drop();
        test_async_abort();
        test_late_lock();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops for reset deassertion and ext_lock (min 2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, cycles all resets stay asserted in HOLD (1..255).
REQ-003 SHALL have parameter STAGE_GAP, default 4, cycles between successive staged releases (1..255).
REQ-004 SHALL have port clk_100MHz  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port sysreset_n  input  1  system reset; asynchronous and active-low.
REQ-006 SHALL have port ext_lock  input  1  clock-generator locked flag, asynchronous to clk_100MHz.
REQ-007 SHALL have port sw_reset_req  input  1  synchronous single-cycle software reset request.
REQ-008 SHALL have port bus_rst_n  output  1  interconnect reset, active-low, released first.
REQ-009 SHALL have port periph_rst_n  output  1  peripheral reset, active-low, released second.
REQ-010 SHALL have port cpu_rst_n  output  1  processor reset, active-low, released last.
REQ-011 SHALL have port rst_done  output  1  high only in RUN.
REQ-012 SHALL have port rst_count  output  8  saturating count of warm-reset events since last sysreset_n.

Function
REQ-013 SHALL implement FSM states RESET, WAIT_LOCK, HOLD, REL_BUS, REL_PERIPH, RUN; all outputs registered.
REQ-014 SHALL assert asynchronously: sysreset_n low forces state RESET, all *_rst_n = 0, rst_done = 0, rst_count = 0, synchronizers cleared, within the same time step.
REQ-015 SHALL deassert synchronously: internal reset released only after sysreset_n seen high on SYNC_STAGES consecutive edges.
REQ-016 SHALL pass ext_lock through a SYNC_STAGES-flop synchronizer (lock_s) before any use.
REQ-017 RESET -> WAIT_LOCK on first edge the internal reset is released.
REQ-018 WAIT_LOCK -> HOLD on the edge lock_s is high; hold counter loaded with HOLD_CYCLES-1.
REQ-019 HOLD lasts exactly HOLD_CYCLES cycles, then -> REL_BUS; bus_rst_n goes 1 on that edge.
REQ-020 REL_BUS lasts exactly STAGE_GAP cycles, then -> REL_PERIPH; periph_rst_n goes 1 on that edge.
REQ-021 REL_PERIPH lasts exactly STAGE_GAP cycles, then -> RUN; cpu_rst_n and rst_done go 1 on that edge.
REQ-022 Release order SHALL be invariant: periph_rst_n never 1 while bus_rst_n 0; cpu_rst_n never 1 while periph_rst_n 0.
REQ-023 lock_s low in HOLD, REL_BUS, REL_PERIPH or RUN -> WAIT_LOCK next edge; all *_rst_n = 0, rst_done = 0.
REQ-024 sw_reset_req high in RUN -> HOLD next edge; all *_rst_n = 0, rst_done = 0, hold counter reloaded.
REQ-025 sw_reset_req SHALL be ignored in every state except RUN.
REQ-026 lock_s low and sw_reset_req high on the same RUN edge: lock loss wins (-> WAIT_LOCK); one event counted.
REQ-027 rst_count SHALL increment by 1 on each REQ-023 exit from a non-WAIT_LOCK state and each accepted REQ-024 request; saturates at 255.
REQ-028 Counters SHALL be 8 bits; no wrap-around of the hold/gap counter to re-extend a phase.

Reset
REQ-029 Reset values: state RESET, bus_rst_n 0, periph_rst_n 0, cpu_rst_n 0, rst_done 0, rst_count 0, all synchronizer flops 0.
REQ-030 sysreset_n asserted mid-sequence or in RUN SHALL abort immediately to REQ-029 values; sequence restarts from RESET.

Verification (defaults SYNC_STAGES=2, HOLD_CYCLES=16, STAGE_GAP=4; T = edge entering HOLD)
REQ-031 ext_lock held 1, sysreset_n released -> HOLD entered within 5 edges; bus_rst_n 1 at T+16, periph_rst_n 1 at T+20, cpu_rst_n and rst_done 1 at T+24.
REQ-032 ext_lock 0 during release, raised 50 cycles later -> FSM stays WAIT_LOCK with all resets 0 until lock_s high, then REQ-031 timing from new T.
REQ-033 One-cycle sw_reset_req in RUN -> all resets 0 next edge, rst_count 1, full staged release repeats (bus at +16, cpu at +24).
REQ-034 ext_lock dropped while in REL_BUS -> WAIT_LOCK, bus_rst_n back to 0, rst_count 1; sw_reset_req pulsed in HOLD -> ignored, rst_count unchanged.
REQ-035 sysreset_n pulled low asynchronously in REL_PERIPH between edges -> outputs 0 and rst_count 0 before next edge; 300 sw_reset_req events in RUN -> rst_count saturates at 255.
